pc_fetch_sequencer: RTL and testbench

//  Owns the architectural PC register and sequences instruction fetch for the CPU.

---
 rtl/pc_fetch_sequencer.sv | 113 +++++++++++
 tb/tb_pc_fetch_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
// Holds the architectural PC and runs the fetch handshake with a variable-latency
// instruction memory. Each instruction goes through FETCH -> WAIT -> ISSUE. The next
// PC is committed only when ISSUE is left. HALT and ERR are terminal until reset.
// All outputs are decoded from registered state, so no input has a combinational
// path to an output.
module pc_fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] pc_cur,
    input  logic [15:0] pc_next,
    input  logic        br_reg,
    input  logic [15:0] br_target,
    input  logic        stall,
    input  logic        halt,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic        halted,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_HALT,
        S_ERR
    } state_e;

    // Last WAIT count value before the watchdog trips. WAIT holds for MAX_WAIT cycles in total.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    // Next-state, PC commit, instruction capture and watchdog count.
    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no path leaves it unassigned (no latch).
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        wait_cnt_d = wait_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // The request is a single cycle. Any imem_rdy seen here belongs to no fetch.
                wait_cnt_d = 8'd0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rdy) begin
                    instr_d = imem_data;
                    state_d = S_ISSUE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_ISSUE: begin
                if (halt) begin
                    state_d = S_HALT;
                end else if (!stall) begin
                    // The PC is halfword aligned. Bit 0 of either source is dropped.
                    pc_d    = (br_reg ? br_target : pc_next) & 16'hFFFE;
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers. Asynchronous reset aborts any fetch that is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 16'h0000;
            wait_cnt_q <= 8'd0;
        end else begin
            // NOTE: use non-blocking assignments in clocked blocks, so every flop samples the values from before the edge.
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign pc_cur      = pc_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign imem_req    = (state_q == S_FETCH);
    assign instr_valid = (state_q == S_ISSUE);
    assign halted      = (state_q == S_HALT);
    assign err         = (state_q == S_ERR);

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Testbench for pc_fetch_sequencer. The bench acts as the instruction memory with
// a random response latency. It also acts as the PC control adder and as
// decode/execute. The expected PC is computed from the commit rule: the branch
// target or PC+2, with bit 0 cleared.
module tb_pc_fetch_sequencer;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int          MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc_cur;
    logic [15:0] pc_next;
    logic        br_reg;
    logic [15:0] br_target;
    logic        stall;
    logic        halt;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic        halted;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_pc;

    pc_fetch_sequencer #(
        .RESET_PC(RESET_PC),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_cur     (pc_cur),
        .pc_next    (pc_next),
        .br_reg     (br_reg),
        .br_target  (br_target),
        .stall      (stall),
        .halt       (halt),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdy   (imem_rdy),
        .imem_data  (imem_data),
        .instr      (instr),
        .instr_valid(instr_valid),
        .halted     (halted),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Advance one clock. Outputs are sampled and inputs are driven 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_rdy  = 1'b0;
        imem_data = 16'h0000;
        stall     = 1'b0;
        halt      = 1'b0;
        br_reg    = 1'b0;
        pc_next   = 16'h0000;
        br_target = 16'h0000;
    endtask

    // Reset, then release. Returns one cycle after IDLE, with the DUT in FETCH.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        exp_pc = RESET_PC;
        step();
    endtask

    // Run one instruction. The DUT must be in FETCH on entry.
    // The memory answers in WAIT cycle k.
    // Decode stalls for stall_n ISSUE cycles.
    // The instruction then commits (pcn/br/brt), or halts together with stall when do_halt is set.
    task automatic run_instr(input int k, input int stall_n, input logic [15:0] pcn,
                             input logic br, input logic [15:0] brt, input logic do_halt);
        logic [15:0] data;
        data = 16'($urandom);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0)
            $display("FAIL fetch_req: req=%b addr=%h valid=%b, want req=1 addr=%h valid=0",
                     imem_req, imem_addr, instr_valid, exp_pc);
        else checks = checks; // keep count symmetric
        if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0) errors++;
        // A stray rdy carrying the wrong data during FETCH must be ignored.
        imem_rdy  = 1'($urandom_range(0, 1));
        imem_data = ~data;
        step();
        imem_data = data;
        for (int i = 1; i <= k; i++) begin
            checks++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0 || err !== 1'b0 || pc_cur !== exp_pc) begin
                errors++;
                $display("FAIL wait_state: cycle %0d req=%b valid=%b err=%b pc=%h, want 0/0/0 pc=%h",
                         i, imem_req, instr_valid, err, pc_cur, exp_pc);
            end
            imem_rdy = (i == k);
            step();
        end
        imem_rdy = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr !== data || pc_cur !== exp_pc || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL issue: valid=%b instr=%h pc=%h req=%b, want 1 instr=%h pc=%h req=0",
                     instr_valid, instr, pc_cur, imem_req, data, exp_pc);
        end
        for (int s = 0; s < stall_n; s++) begin
            stall     = 1'b1;
            imem_rdy  = 1'($urandom_range(0, 1));
            imem_data = 16'($urandom);
            pc_next   = 16'($urandom);
            step();
            checks++;
            if (instr_valid !== 1'b1 || instr !== data || pc_cur !== exp_pc || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: stall %0d valid=%b instr=%h pc=%h req=%b, want 1 %h %h 0",
                         s, instr_valid, instr, pc_cur, imem_req, data, exp_pc);
            end
        end
        stall     = do_halt;
        halt      = do_halt;
        pc_next   = pcn;
        br_reg    = br;
        br_target = brt;
        imem_rdy  = 1'($urandom_range(0, 1));
        step();
        idle_inputs();
        if (do_halt) begin
            checks++;
            if (halted !== 1'b1 || pc_cur !== exp_pc || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL halt_enter: halted=%b pc=%h req=%b valid=%b, want 1 pc=%h 0 0",
                         halted, pc_cur, imem_req, instr_valid, exp_pc);
            end
        end else begin
            exp_pc = (br ? brt : pcn) & 16'hFFFE;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_pc || pc_cur !== exp_pc || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL commit: req=%b addr=%h pc=%h valid=%b, want req=1 pc=%h valid=0",
                         imem_req, imem_addr, pc_cur, instr_valid, exp_pc);
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        step();
        checks++;
        if (pc_cur !== RESET_PC || imem_addr !== RESET_PC || instr !== 16'h0000 || imem_req !== 1'b0 ||
            instr_valid !== 1'b0 || halted !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: pc=%h addr=%h instr=%h req=%b valid=%b halted=%b err=%b",
                     pc_cur, imem_addr, instr, imem_req, instr_valid, halted, err);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: req=%b want 0 in first cycle after release", imem_req);
        end
        step();
        exp_pc = RESET_PC;
    endtask

    task automatic test_sequential();
        for (int n = 0; n < 3; n++) run_instr(1, 0, exp_pc + 16'd2, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_branch();
        run_instr(1, 0, 16'h0040, 1'b0, 16'h7777, 1'b0);
        run_instr(2, 0, 16'hFFFF, 1'b0, 16'h0000, 1'b0);   // bit 0 of pc_next is dropped
        run_instr(1, 0, 16'h0000, 1'b0, 16'h0000, 1'b0);   // wrap after FFFE is taken as given
    endtask

    task automatic test_br_reg();
        run_instr(1, 0, 16'h0010, 1'b1, 16'h1235, 1'b0);
    endtask

    task automatic test_stall();
        run_instr(1, 4, exp_pc + 16'd2, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            run_instr(int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), 16'($urandom),
                      1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
        end
    endtask

    task automatic test_max_wait_boundary();
        run_instr(MAX_WAIT, 0, exp_pc + 16'd2, 1'b0, 16'h0000, 1'b0);  // rdy in last allowed WAIT cycle
    endtask

    task automatic test_halt();
        run_instr(1, 0, 16'h2222, 1'b0, 16'h0000, 1'b1);
        for (int n = 0; n < 20; n++) begin
            imem_rdy = 1'($urandom_range(0, 1));
            stall    = 1'($urandom_range(0, 1));
            step();
            checks++;
            if (imem_req !== 1'b0 || halted !== 1'b1 || pc_cur !== exp_pc || err !== 1'b0) begin
                errors++;
                $display("FAIL halt_sticky: cycle %0d req=%b halted=%b pc=%h err=%b, want 0 1 %h 0",
                         n, imem_req, halted, pc_cur, err, exp_pc);
            end
        end
        idle_inputs();
    endtask

    task automatic test_watchdog();
        int n;
        do_reset();
        step();   // first WAIT cycle
        n = 0;
        while (err !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (n != MAX_WAIT) begin
            errors++;
            $display("FAIL watchdog_time: err after %0d WAIT cycles, want %0d", n, MAX_WAIT);
        end
        for (int c = 0; c < 3; c++) begin
            imem_rdy = 1'b1;
            step();
        end
        imem_rdy = 1'b0;
        checks++;
        if (err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL watchdog_sticky: err=%b req=%b valid=%b, want 1 0 0", err, imem_req, instr_valid);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        run_instr(1, 0, 16'h0300, 1'b0, 16'h0000, 1'b0);  // move the PC away from its reset value
        step();
        step();   // second WAIT cycle of the fetch at 0300
        imem_rdy  = 1'b1;
        imem_data = 16'hBEEF;
        rst_n     = 1'b0;
        #1;
        checks++;
        if (pc_cur !== RESET_PC || instr !== 16'h0000 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
            halted !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait: pc=%h instr=%h req=%b valid=%b halted=%b err=%b",
                     pc_cur, instr, imem_req, instr_valid, halted, err);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (instr !== 16'h0000 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL late_rdy_dropped: instr=%h valid=%b, want 0000 0", instr, instr_valid);
        end
        imem_rdy = 1'b0;
        exp_pc   = RESET_PC;
        run_instr(2, 0, exp_pc + 16'd2, 1'b0, 16'h0000, 1'b0);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_br_reg();
        test_stall();
        test_random();
        test_max_wait_boundary();
        test_halt();
        test_watchdog();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
